// File: rtl/alarm_clock_ctrl_pkg.sv
// rtl/alarm_clock_ctrl_pkg.sv - shared encodings and helpers for the alarm clock sequencer
package alarm_clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN         = 3'd0,
        ST_ADJ_CLK_HR  = 3'd1,
        ST_ADJ_CLK_MIN = 3'd2,
        ST_ADJ_ALM_HR  = 3'd3,
        ST_ADJ_ALM_MIN = 3'd4
    } state_t;

    // One-hot field select, bit order {ALM_MIN, ALM_HR, CLK_MIN, CLK_HR}
    localparam logic [3:0] FIELD_NONE    = 4'b0000;
    localparam logic [3:0] FIELD_CLK_HR  = 4'b0001;
    localparam logic [3:0] FIELD_CLK_MIN = 4'b0010;
    localparam logic [3:0] FIELD_ALM_HR  = 4'b0100;
    localparam logic [3:0] FIELD_ALM_MIN = 4'b1000;

    // Winning button after same-cycle priority resolution (c > r > l > u > d)
    typedef enum logic [2:0] {
        BTN_NONE = 3'd0,
        BTN_C    = 3'd1,
        BTN_R    = 3'd2,
        BTN_L    = 3'd3,
        BTN_U    = 3'd4,
        BTN_D    = 3'd5
    } btn_t;

    typedef struct packed {
        logic       sec_en;
        logic       min_en;
        logic       hr_en;
        logic       sec_clr;
        logic       tmin_up;
        logic       tmin_dn;
        logic       thr_up;
        logic       thr_dn;
        logic       amin_up;
        logic       amin_dn;
        logic       ahr_up;
        logic       ahr_dn;
        logic       adjust;
        logic [3:0] field_sel;
    } ctrl_out_t;

    function automatic btn_t btn_pick(input logic c, input logic r, input logic l,
                                      input logic u, input logic d);
        btn_t b;
        if (c)      b = BTN_C;
        else if (r) b = BTN_R;
        else if (l) b = BTN_L;
        else if (u) b = BTN_U;
        else if (d) b = BTN_D;
        else        b = BTN_NONE;
        return b;
    endfunction

    function automatic logic [3:0] field_of(input state_t s);
        logic [3:0] f;
        case (s)
            ST_ADJ_CLK_HR:  f = FIELD_CLK_HR;
            ST_ADJ_CLK_MIN: f = FIELD_CLK_MIN;
            ST_ADJ_ALM_HR:  f = FIELD_ALM_HR;
            ST_ADJ_ALM_MIN: f = FIELD_ALM_MIN;
            default:        f = FIELD_NONE;
        endcase
        return f;
    endfunction

    function automatic state_t adj_next(input state_t s);
        state_t n;
        case (s)
            ST_ADJ_CLK_HR:  n = ST_ADJ_CLK_MIN;
            ST_ADJ_CLK_MIN: n = ST_ADJ_ALM_HR;
            ST_ADJ_ALM_HR:  n = ST_ADJ_ALM_MIN;
            default:        n = ST_ADJ_CLK_HR;
        endcase
        return n;
    endfunction

    function automatic state_t adj_prev(input state_t s);
        state_t n;
        case (s)
            ST_ADJ_CLK_HR:  n = ST_ADJ_ALM_MIN;
            ST_ADJ_CLK_MIN: n = ST_ADJ_CLK_HR;
            ST_ADJ_ALM_HR:  n = ST_ADJ_CLK_MIN;
            default:        n = ST_ADJ_ALM_HR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alarm_clock_ctrl_if.sv
// rtl/alarm_clock_ctrl_if.sv - button/datapath bundle between conditioning logic and the sequencer
interface alarm_clock_ctrl_if #(
    parameter int HR_W  = 5,
    parameter int MIN_W = 6
);
    logic             tick_1hz;
    logic             btn_c;
    logic             btn_l;
    logic             btn_r;
    logic             btn_u;
    logic             btn_d;
    logic             alarm_en;
    logic [MIN_W-1:0] sec;
    logic [MIN_W-1:0] t_min;
    logic [HR_W-1:0]  t_hr;
    logic [MIN_W-1:0] a_min;
    logic [HR_W-1:0]  a_hr;

    logic             sec_en;
    logic             min_en;
    logic             hr_en;
    logic             sec_clr;
    logic             tmin_up;
    logic             tmin_dn;
    logic             thr_up;
    logic             thr_dn;
    logic             amin_up;
    logic             amin_dn;
    logic             ahr_up;
    logic             ahr_dn;
    logic             adjust;
    logic [3:0]       field_sel;
    logic             ringing;
    logic             alarm_led;

    modport master (
        output tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d, alarm_en,
        output sec, t_min, t_hr, a_min, a_hr,
        input  sec_en, min_en, hr_en, sec_clr,
        input  tmin_up, tmin_dn, thr_up, thr_dn,
        input  amin_up, amin_dn, ahr_up, ahr_dn,
        input  adjust, field_sel, ringing, alarm_led
    );

    modport slave (
        input  tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d, alarm_en,
        input  sec, t_min, t_hr, a_min, a_hr,
        output sec_en, min_en, hr_en, sec_clr,
        output tmin_up, tmin_dn, thr_up, thr_dn,
        output amin_up, amin_dn, ahr_up, ahr_dn,
        output adjust, field_sel, ringing, alarm_led
    );

endinterface

// File: rtl/alarm_clock_ctrl_alarm_ringer.sv
// rtl/alarm_clock_ctrl_alarm_ringer.sv - alarm match edge detect, ring timer, blink and stop logic
module alarm_ringer #(
    parameter int RING_S = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic match,
    input  logic arm,
    input  logic tick,
    input  logic any_btn,
    input  logic run,
    output logic ringing,
    output logic led,
    output logic consume
);

    localparam logic [7:0] RING_LIM = 8'(RING_S);

    logic       match_d;
    logic [7:0] ring_cnt;
    logic [7:0] cnt_inc;
    logic       blink;
    logic       start;
    logic       stop;

    // Button pressed while ringing only silences the buzzer
    assign consume = ringing && any_btn;
    assign cnt_inc = ring_cnt + 8'd1;

    // Rising edge of match only; a simultaneous button press is left to the FSM
    // so a press is never both honoured and followed by a ring
    assign start = run && arm && match && !match_d && !ringing && !any_btn;
    assign stop  = ringing && (any_btn || !arm || (tick && (cnt_inc == RING_LIM)));
    assign led   = blink;

    // Previous-cycle match, tracked in every state so leaving adjust onto a match stays quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            match_d <= 1'b0;
        end else begin
            match_d <= match;
        end
    end

    // Ring counter and blink: count ticks while ringing, clear everything on stop
    always_ff @(posedge clk) begin
        if (rst) begin
            ringing  <= 1'b0;
            ring_cnt <= 8'd0;
            blink    <= 1'b0;
        end else if (stop) begin
            ringing  <= 1'b0;
            ring_cnt <= 8'd0;
            blink    <= 1'b0;
        end else if (start) begin
            ringing  <= 1'b1;
            ring_cnt <= 8'd0;
            blink    <= 1'b0;
        end else if (ringing && tick) begin
            ring_cnt <= cnt_inc;
            blink    <= !blink;
        end
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// rtl/alarm_clock_ctrl.sv - mode FSM, run cascade and adjust strobes for the alarm clock
module alarm_clock_ctrl
    import alarm_clock_ctrl_pkg::*;
#(
    parameter int RING_S = 60,
    parameter int HR_W   = 5,
    parameter int MIN_W  = 6
) (
    input logic               clk,
    input logic               rst,
    alarm_clock_ctrl_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    ctrl_out_t        out_d;
    ctrl_out_t        out_q;
    logic             dirty_q;
    btn_t             btn_sel;
    logic             any_btn;
    logic             consume;
    logic             match;
    logic             ring;
    logic             led;
    logic             run;

    logic [MIN_W-1:0] sec;
    logic [MIN_W-1:0] t_min;
    logic [MIN_W-1:0] a_min;
    logic [HR_W-1:0]  t_hr;
    logic [HR_W-1:0]  a_hr;

    assign sec   = bus.sec;
    assign t_min = bus.t_min;
    assign a_min = bus.a_min;
    assign t_hr  = bus.t_hr;
    assign a_hr  = bus.a_hr;

    assign any_btn = bus.btn_c | bus.btn_l | bus.btn_r | bus.btn_u | bus.btn_d;
    assign match   = (t_hr == a_hr) && (t_min == a_min) && (sec == '0);
    assign run     = (state_q == ST_RUN);

    // A dismissing press is swallowed whole: no mode change, no strobe
    assign btn_sel = consume ? BTN_NONE
                             : btn_pick(bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d);

    alarm_ringer #(
        .RING_S (RING_S)
    ) u_ringer (
        .clk     (clk),
        .rst     (rst),
        .match   (match),
        .arm     (bus.alarm_en),
        .tick    (bus.tick_1hz),
        .any_btn (any_btn),
        .run     (run),
        .ringing (ring),
        .led     (led),
        .consume (consume)
    );

    // Mode state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mode and the strobes to issue on the following cycle
    always_comb begin
        state_d = state_q;
        out_d   = '0;
        case (state_q)
            ST_RUN: begin
                if (btn_sel == BTN_C) begin
                    state_d = ST_ADJ_CLK_HR;
                end
                out_d.sec_en = bus.tick_1hz;
                out_d.min_en = bus.tick_1hz && (sec == MIN_W'(59));
                out_d.hr_en  = bus.tick_1hz && (sec == MIN_W'(59)) && (t_min == MIN_W'(59));
            end
            default: begin
                case (btn_sel)
                    BTN_C: state_d = ST_RUN;
                    BTN_R: state_d = adj_next(state_q);
                    BTN_L: state_d = adj_prev(state_q);
                    BTN_U: begin
                        case (state_q)
                            ST_ADJ_CLK_HR:  out_d.thr_up  = 1'b1;
                            ST_ADJ_CLK_MIN: out_d.tmin_up = 1'b1;
                            ST_ADJ_ALM_HR:  out_d.ahr_up  = 1'b1;
                            default:        out_d.amin_up = 1'b1;
                        endcase
                    end
                    BTN_D: begin
                        case (state_q)
                            ST_ADJ_CLK_HR:  out_d.thr_dn  = 1'b1;
                            ST_ADJ_CLK_MIN: out_d.tmin_dn = 1'b1;
                            ST_ADJ_ALM_HR:  out_d.ahr_dn  = 1'b1;
                            default:        out_d.amin_dn = 1'b1;
                        endcase
                    end
                    default: ;
                endcase
                out_d.sec_clr = (state_d == ST_RUN) && dirty_q;
            end
        endcase
        out_d.adjust    = (state_d != ST_RUN);
        out_d.field_sel = field_of(state_d);
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    // Dirty flag: time was edited during this adjust session, so seconds restart on exit
    always_ff @(posedge clk) begin
        if (rst) begin
            dirty_q <= 1'b0;
        end else if ((state_q == ST_RUN) && (state_d != ST_RUN)) begin
            dirty_q <= 1'b0;
        end else if (out_d.tmin_up || out_d.tmin_dn || out_d.thr_up || out_d.thr_dn) begin
            dirty_q <= 1'b1;
        end
    end

    assign bus.sec_en    = out_q.sec_en;
    assign bus.min_en    = out_q.min_en;
    assign bus.hr_en     = out_q.hr_en;
    assign bus.sec_clr   = out_q.sec_clr;
    assign bus.tmin_up   = out_q.tmin_up;
    assign bus.tmin_dn   = out_q.tmin_dn;
    assign bus.thr_up    = out_q.thr_up;
    assign bus.thr_dn    = out_q.thr_dn;
    assign bus.amin_up   = out_q.amin_up;
    assign bus.amin_dn   = out_q.amin_dn;
    assign bus.ahr_up    = out_q.ahr_up;
    assign bus.ahr_dn    = out_q.ahr_dn;
    assign bus.adjust    = out_q.adjust;
    assign bus.field_sel = out_q.field_sel;
    assign bus.ringing   = ring;
    assign bus.alarm_led = led;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// tb/tb_alarm_clock_ctrl.sv - directed self-checking bench for alarm_clock_ctrl
module tb_alarm_clock_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alarm_clock_ctrl_if #(.HR_W(5), .MIN_W(6)) bus ();

    alarm_clock_ctrl #(
        .RING_S (60),
        .HR_W   (5),
        .MIN_W  (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // b = {c, r, l, u, d}
    task automatic press(input logic [4:0] b);
        {bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d} = b;
        cyc();
        {bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d} = 5'b0;
    endtask

    task automatic tick();
        bus.tick_1hz = 1'b1;
        cyc();
        bus.tick_1hz = 1'b0;
    endtask

    function automatic logic [7:0] strobes();
        return {bus.tmin_up, bus.tmin_dn, bus.thr_up, bus.thr_dn,
                bus.amin_up, bus.amin_dn, bus.ahr_up, bus.ahr_dn};
    endfunction

    function automatic logic [2:0] runen();
        return {bus.sec_en, bus.min_en, bus.hr_en};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.tick_1hz = 1'b0;
        {bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_u, bus.btn_d} = 5'b0;
        bus.alarm_en = 1'b0;
        bus.sec   = 6'd10;
        bus.t_min = 6'd0;
        bus.t_hr  = 5'd0;
        bus.a_min = 6'd30;
        bus.a_hr  = 5'd7;

        repeat (3) cyc();
        check("rst_runen",   32'(runen()),         32'd0);
        check("rst_strobes", 32'(strobes()),       32'd0);
        check("rst_field",   32'(bus.field_sel),   32'd0);
        check("rst_adjust",  32'(bus.adjust),      32'd0);
        check("rst_ring",    32'({bus.ringing, bus.alarm_led, bus.sec_clr}), 32'd0);
        rst = 1'b0;
        cyc();

        // three plain ticks
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tick_runen", 32'(runen()),       32'b100);
            check("tick_field", 32'(bus.field_sel), 32'd0);
            cyc();
            check("tick_one_cycle", 32'(runen()),   32'd0);
        end

        // cascade boundaries
        bus.sec = 6'd59; bus.t_min = 6'd59;
        tick();
        check("cascade_all", 32'(runen()), 32'b111);
        cyc();
        check("cascade_off", 32'(runen()), 32'd0);
        bus.t_min = 6'd10;
        tick();
        check("cascade_min", 32'(runen()), 32'b110);
        bus.sec = 6'd10;
        cyc();

        // time minute adjust session
        press(5'b10000);
        check("adj_enter_field", 32'(bus.field_sel), 32'b0001);
        check("adj_enter_adj",   32'(bus.adjust),    32'd1);
        press(5'b01000);
        check("adj_r_field", 32'(bus.field_sel), 32'b0010);
        press(5'b00010);
        check("tmin_up1", 32'(strobes()), 32'b1000_0000);
        cyc();
        check("tmin_up1_off", 32'(strobes()), 32'd0);
        press(5'b00010);
        check("tmin_up2", 32'(strobes()), 32'b1000_0000);
        tick();
        check("adj_paused", 32'(runen()), 32'd0);
        press(5'b10000);
        check("exit_adjust",  32'(bus.adjust),    32'd0);
        check("exit_field",   32'(bus.field_sel), 32'd0);
        check("exit_sec_clr", 32'(bus.sec_clr),   32'd1);
        cyc();
        check("sec_clr_once", 32'(bus.sec_clr),   32'd0);

        // reverse navigation and priority
        press(5'b10000);
        press(5'b00100);
        check("l_wrap_field", 32'(bus.field_sel), 32'b1000);
        press(5'b00011);
        check("u_over_d", 32'(strobes()), 32'b0000_1000);
        press(5'b11000);
        check("c_over_r_adj",   32'(bus.adjust),    32'd0);
        check("c_over_r_field", 32'(bus.field_sel), 32'd0);
        check("clean_no_clr",   32'(bus.sec_clr),   32'd0);

        // hour down marks the session dirty
        press(5'b10000);
        press(5'b00001);
        check("thr_dn", 32'(strobes()), 32'b0001_0000);
        press(5'b10000);
        check("thr_sec_clr", 32'(bus.sec_clr), 32'd1);
        cyc();

        // alarm ring with auto-stop
        bus.alarm_en = 1'b1;
        bus.t_hr = 5'd7; bus.t_min = 6'd30; bus.sec = 6'd59;
        cyc();
        check("pre_match_ring", 32'(bus.ringing), 32'd0);
        bus.sec = 6'd0;
        cyc();
        check("ring_start", 32'({bus.ringing, bus.alarm_led}), 32'b10);
        for (int k = 1; k < 60; k++) begin
            tick();
            check("ring_hold", 32'(bus.ringing),   32'd1);
            check("ring_led",  32'(bus.alarm_led), 32'(k & 1));
        end
        tick();
        check("ring_autostop", 32'({bus.ringing, bus.alarm_led}), 32'd0);
        repeat (3) cyc();
        check("no_retrigger", 32'(bus.ringing), 32'd0);

        // dismiss by button
        bus.sec = 6'd1; cyc();
        bus.sec = 6'd0; cyc();
        check("ring2_start", 32'(bus.ringing), 32'd1);
        tick();
        check("ring2_led", 32'(bus.alarm_led), 32'd1);
        press(5'b10000);
        check("dismiss_ring", 32'({bus.ringing, bus.alarm_led}), 32'd0);
        check("dismiss_adj",  32'(bus.adjust),    32'd0);
        check("dismiss_fld",  32'(bus.field_sel), 32'd0);
        cyc();
        check("dismiss_stay", 32'(bus.adjust), 32'd0);

        // dismiss by disarming
        bus.sec = 6'd1; cyc();
        bus.sec = 6'd0; cyc();
        check("ring3_start", 32'(bus.ringing), 32'd1);
        bus.alarm_en = 1'b0;
        cyc();
        check("disarm_stop", 32'(bus.ringing), 32'd0);

        // disarmed match
        bus.sec = 6'd1; cyc();
        bus.sec = 6'd0; cyc();
        check("disarmed_none", 32'(bus.ringing), 32'd0);
        repeat (2) cyc();
        check("disarmed_none2", 32'(bus.ringing), 32'd0);

        // match edge during adjust, then return onto the match
        bus.alarm_en = 1'b1;
        bus.sec = 6'd1; cyc();
        press(5'b10000);
        check("adj_for_match", 32'(bus.adjust), 32'd1);
        bus.sec = 6'd0;
        cyc();
        check("adj_no_ring", 32'(bus.ringing), 32'd0);
        press(5'b10000);
        cyc();
        check("return_no_ring", 32'({bus.ringing, bus.adjust}), 32'd0);

        // reset mid-ring
        bus.sec = 6'd1; cyc();
        bus.sec = 6'd0; cyc();
        tick();
        check("ring4_led", 32'({bus.ringing, bus.alarm_led}), 32'b11);
        bus.sec = 6'd5;
        rst = 1'b1;
        cyc();
        check("rst_mid_ring", 32'({bus.ringing, bus.alarm_led}), 32'd0);
        rst = 1'b0;
        cyc();

        // reset mid-adjust
        press(5'b10000);
        bus.btn_u = 1'b1;
        rst = 1'b1;
        cyc();
        bus.btn_u = 1'b0;
        check("rst_mid_adj", 32'({bus.adjust, bus.field_sel}), 32'd0);
        check("rst_mid_adj_strobe", 32'(strobes()), 32'd0);
        rst = 1'b0;
        cyc();
        check("post_rst_adj", 32'(bus.adjust), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
